// File: rtl/reg_bank_arbiter_if.sv
// Bus bundle between two requesters and the shared register bank arbiter.
// The arbiter uses the slave modport; the requester side uses master.
interface reg_bank_arbiter_if #(
  parameter int WIDTH = 4
);
  logic               req_a, req_b;
  logic               we_a, we_b;
  logic [1:0]         addr_a, addr_b;
  logic [WIDTH-1:0]   wdata_a, wdata_b;
  logic               gnt_a, gnt_b;
  logic [WIDTH-1:0]   rdata;
  logic               rvalid;
  logic               rsrc;
  logic [4*WIDTH-1:0] bank_q;

  modport slave (
    input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    output gnt_a, gnt_b, rdata, rvalid, rsrc, bank_q
  );

  modport master (
    output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
    input  gnt_a, gnt_b, rdata, rvalid, rsrc, bank_q
  );
endinterface

// File: rtl/reg_bank_arbiter.sv
// Two-requester arbiter owning a four-entry register bank; one access per cycle
// by the current owner, with bounded bursts while the other side waits.
module reg_bank_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  reg_bank_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  localparam logic [3:0] MAXC = 4'(MAX_BURST);

  state_e                      state_q, state_d;
  logic                        last_b_q, last_b_d;   // 1 = B owned most recently
  logic [3:0]                  cnt_q, cnt_d;
  logic [3:0][WIDTH-1:0]       bank_q, bank_d;
  logic [WIDTH-1:0]            rdata_q, rdata_d;
  logic                        rvalid_q, rvalid_d;
  logic                        rsrc_q, rsrc_d;

  logic             own_b, req_own, req_oth, we_own;
  logic [1:0]       addr_own;
  logic [WIDTH-1:0] wdata_own;
  logic [3:0]       cnt_inc;

  // Steer the owner's inputs; the waiting side only contributes its request.
  assign own_b     = (state_q == OWN_B);
  assign req_own   = own_b ? bus.req_b   : bus.req_a;
  assign req_oth   = own_b ? bus.req_a   : bus.req_b;
  assign we_own    = own_b ? bus.we_b    : bus.we_a;
  assign addr_own  = own_b ? bus.addr_b  : bus.addr_a;
  assign wdata_own = own_b ? bus.wdata_b : bus.wdata_a;
  assign cnt_inc   = (cnt_q >= MAXC) ? MAXC : cnt_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    cnt_d    = cnt_q;
    bank_d   = bank_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    rsrc_d   = rsrc_q;
    case (state_q)
      IDLE: begin
        if (bus.req_a && (!bus.req_b || last_b_q)) begin
          state_d  = OWN_A;
          last_b_d = 1'b0;
          cnt_d    = 4'd0;
        end else if (bus.req_b) begin
          state_d  = OWN_B;
          last_b_d = 1'b1;
          cnt_d    = 4'd0;
        end
      end
      OWN_A, OWN_B: begin
        if (req_own) begin
          if (we_own) begin
            bank_d[addr_own] = wdata_own;
          end else begin
            rdata_d  = bank_q[addr_own];
            rvalid_d = 1'b1;
            rsrc_d   = own_b;
          end
          cnt_d = cnt_inc;
        end
        // Hand over when the owner goes quiet or its burst budget is spent.
        if (req_oth && (!req_own || cnt_inc == MAXC)) begin
          state_d  = own_b ? OWN_A : OWN_B;
          last_b_d = !own_b;
          cnt_d    = 4'd0;
        end else if (!req_own) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      cnt_q    <= 4'd0;
      bank_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rsrc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      cnt_q    <= cnt_d;
      bank_q   <= bank_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rsrc_q   <= rsrc_d;
    end
  end

  assign bus.gnt_a  = (state_q == OWN_A);
  assign bus.gnt_b  = (state_q == OWN_B);
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rsrc   = rsrc_q;
  assign bus.bank_q = bank_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed scenarios then random traffic, every cycle compared against a
// transaction-level model of ownership, bursts and the register bank.
module tb_reg_bank_arbiter;
  localparam int W = 4;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  reg_bank_arbiter_if #(.WIDTH(W)) bus();
  reg_bank_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // model: owner 0 = nobody, 1 = A, 2 = B
  int         m_owner, m_last, m_run;
  bit [W-1:0] m_bank [4];
  bit [W-1:0] m_rdata;
  bit         m_rvalid, m_rsrc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit [4*W-1:0] m_flat();
    bit [4*W-1:0] f;
    for (int i = 0; i < 4; i++) f[i*W +: W] = m_bank[i];
    return f;
  endfunction

  task automatic give(input int who);
    m_owner = who;
    m_last  = who;
    m_run   = 0;
  endtask

  task automatic step(input bit rst,
                      input bit ra, input bit wa, input bit [1:0] aa, input bit [W-1:0] da,
                      input bit rb, input bit wb, input bit [1:0] ab, input bit [W-1:0] db);
    bit         rq [3];
    bit         wr [3];
    bit [1:0]   ad [3];
    bit [W-1:0] dt [3];
    int         other;
    reset = rst;
    bus.req_a = ra; bus.we_a = wa; bus.addr_a = aa; bus.wdata_a = da;
    bus.req_b = rb; bus.we_b = wb; bus.addr_b = ab; bus.wdata_b = db;
    rq[1] = ra; wr[1] = wa; ad[1] = aa; dt[1] = da;
    rq[2] = rb; wr[2] = wb; ad[2] = ab; dt[2] = db;
    rq[0] = 0;  wr[0] = 0;  ad[0] = 0;  dt[0] = 0;
    m_rvalid = 0;
    if (rst) begin
      m_owner = 0; m_last = 2; m_run = 0;
      foreach (m_bank[i]) m_bank[i] = '0;
      m_rdata = '0; m_rsrc = 0;
    end else if (m_owner == 0) begin
      if (rq[1] && rq[2]) give(3 - m_last);
      else if (rq[1])     give(1);
      else if (rq[2])     give(2);
    end else begin
      other = 3 - m_owner;
      if (!rq[m_owner]) begin
        if (rq[other]) give(other);
        else m_owner = 0;
      end else begin
        if (wr[m_owner]) m_bank[ad[m_owner]] = dt[m_owner];
        else begin
          m_rdata  = m_bank[ad[m_owner]];
          m_rvalid = 1;
          m_rsrc   = (m_owner == 2);
        end
        if (m_run < MB) m_run++;
        if (m_run == MB && rq[other]) give(other);
      end
    end
    @(posedge clk);
    #1;
    chk("gnt_a",  32'(bus.gnt_a),  32'(m_owner == 1));
    chk("gnt_b",  32'(bus.gnt_b),  32'(m_owner == 2));
    chk("rvalid", 32'(bus.rvalid), 32'(m_rvalid));
    chk("rdata",  32'(bus.rdata),  32'(m_rdata));
    chk("rsrc",   32'(bus.rsrc),   32'(m_rsrc));
    chk("bank",   32'(bus.bank_q), 32'(m_flat()));
  endtask

  int ga;

  initial begin
    m_owner = 0; m_last = 2; m_run = 0;
    step(1, 0,0,0,0, 0,0,0,0);

    // A writes 0xA to reg 2: grant first, write on the next edge
    step(0, 1,1,2,4'hA, 0,0,0,0);
    chk("r29_gnt_a", 32'(bus.gnt_a), 32'd1);
    step(0, 1,1,2,4'hA, 0,0,0,0);
    chk("r29_bank", 32'(bus.bank_q[11:8]), 32'hA);

    // both requesting continuously: 4 A grants, then B takes over
    step(1, 0,0,0,0, 0,0,0,0);
    ga = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1,0,0,0, 1,0,1,0);
      if (bus.gnt_a) ga++;
      chk("r30_excl", 32'(bus.gnt_a & bus.gnt_b), 32'd0);
    end
    chk("r30_a_cycles", 32'(ga), 32'd4);
    chk("r30_gnt_b", 32'(bus.gnt_b), 32'd1);

    // B writes 5 to reg 1 then reads it back
    step(1, 0,0,0,0, 0,0,0,0);
    step(0, 0,0,0,0, 1,1,1,4'h5);
    step(0, 0,0,0,0, 1,1,1,4'h5);
    step(0, 0,0,0,0, 1,0,1,0);
    chk("r31_rdata", 32'(bus.rdata), 32'h5);
    chk("r31_rsrc", 32'(bus.rsrc), 32'd1);
    step(0, 0,0,0,0, 0,0,0,0);
    chk("r31_pulse", 32'(bus.rvalid), 32'd0);

    // A drops with B waiting (B unganted write ignored), then idle
    step(0, 1,0,0,0, 0,0,0,0);
    step(0, 1,0,0,0, 1,1,3,4'h7);
    chk("r34_bank3", 32'(bus.bank_q[15:12]), 32'h0);
    step(0, 0,0,0,0, 1,1,3,4'h7);
    chk("r32_handover", 32'(bus.gnt_b), 32'd1);
    step(0, 0,0,0,0, 0,0,0,0);

    // reset during the third cycle of an A burst writing 0xF to reg 0
    step(0, 1,1,0,4'hF, 0,0,0,0);
    step(0, 1,1,0,4'hF, 0,0,0,0);
    step(0, 1,1,0,4'hF, 0,0,0,0);
    step(1, 1,1,0,4'hF, 0,0,0,0);
    chk("r33_bank", 32'(bus.bank_q), 32'h0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) == 0),
           ($urandom_range(9) < 7), 1'($urandom), 2'($urandom), W'($urandom),
           ($urandom_range(9) < 7), 1'($urandom), 2'($urandom), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_bank_arbiter.md
REG_BANK_ARBITER -- requirements
Module: reg_bank_arbiter

Interface
REQ-001 Parameter WIDTH, default 4, data width of each bank register.
REQ-002 Parameter MAX_BURST, default 4, max consecutive accesses by one owner while the other requester waits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_a, req_b  input  1 each  access request from requester A / B.
REQ-006 we_a, we_b  input  1 each  1 = write, 0 = read.
REQ-007 addr_a, addr_b  input  2 each  bank register index 0..3.
REQ-008 wdata_a, wdata_b  input  WIDTH each  write data.
REQ-009 gnt_a, gnt_b  output  1 each  ownership grant; never both 1.
REQ-010 rdata  output  WIDTH  last read value.
REQ-011 rvalid  output  1  one-cycle pulse, rdata updated this cycle.
REQ-012 rsrc  output  1  owner of the read shown on rdata (0 = A, 1 = B).
REQ-013 bank_q  output  4*WIDTH  bank contents; reg i at bits [i*WIDTH +: WIDTH].

Function
REQ-014 Block SHALL hold four WIDTH-bit registers; only granted accesses modify them.
REQ-015 FSM states SHALL be IDLE, OWN_A, OWN_B; gnt_a = (state==OWN_A), gnt_b = (state==OWN_B), driven from registered state only.
REQ-016 Access SHALL occur on any edge where gnt_x=1 and req_x=1; exactly one access per cycle.
REQ-017 Write access: bank[addr_x] <= wdata_x at that edge.
REQ-018 Read access: rdata <= bank[addr_x], rsrc <= x, rvalid <= 1 at that edge; rvalid SHALL be 0 in every cycle following a non-read edge.
REQ-019 IDLE: only req_a -> OWN_A; only req_b -> OWN_B; both -> requester not equal to last_owner; neither -> IDLE. No access occurs in IDLE (grant latency 1 cycle).
REQ-020 last_owner SHALL update on every entry to OWN_A/OWN_B.
REQ-021 OWN_x with req_x=0: no access; next state OWN_other if req_other=1, else IDLE.
REQ-022 Burst counter SHALL clear on entry to an OWN state and increment on each access, saturating at MAX_BURST.
REQ-023 OWN_x with access and counter reaching MAX_BURST on that edge: next state OWN_other if req_other=1; otherwise remain OWN_x with counter saturated.
REQ-024 OWN_x with counter already at MAX_BURST and req_other rising: switch to OWN_other after the current cycle's access.
REQ-025 Read of an address written on an earlier edge SHALL return the new value; no bypass within the same edge required (single access per cycle).
REQ-026 Inputs of the non-granted requester SHALL be ignored entirely.

Reset
REQ-027 On reset edge: state IDLE, gnt_a=gnt_b=0, all bank registers 0, rdata 0, rvalid 0, rsrc 0, counter 0, last_owner=B (A wins first tie).
REQ-028 Reset SHALL take priority over any access in the same cycle, including mid-burst; the access is discarded.

Verification
REQ-029 Reset, then req_a=we_a=1, addr_a=2, wdata_a=0xA held -> gnt_a=1 next cycle; bank_q[11:8]=0xA after first granted edge.
REQ-030 req_a=req_b=1 from IDLE after reset, both continuous, MAX_BURST=4 -> gnt_a for 4 cycles, then gnt_b for 4 cycles, alternating, never both high.
REQ-031 Write 0x5 to reg 1 via B, then B read addr 1 -> rvalid pulse 1 cycle, rdata=0x5, rsrc=1.
REQ-032 A owns, drops req_a while req_b=1 -> gnt_b=1 next cycle, no idle gap; with req_b=0 -> IDLE, both grants 0.
REQ-033 Reset asserted during third cycle of A write burst to reg 0 (0xF) -> bank_q=0, grants 0, rvalid 0 next cycle.
REQ-034 A granted, B drives req_b=1, we_b=1, addr_b=3, wdata_b=0x7 without grant -> bank[3] unchanged until gnt_b=1.
